// File: rtl/uart_core_param.sv
// ---------------------------------------------------------------------------
// uart_core_param
//   Full-duplex UART core with configurable data width, oversample ratio,
//   parity and stop bits. Byte-side traffic uses valid/ready handshakes.
//   The receiver rejects start-bit glitches and reports framing, parity and
//   overrun conditions.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9)
//   OVS        sysclk cycles per serial bit (>= 4)
//   PARITY_EN  1 = append / check a parity bit
//   PARITY_ODD 1 = odd parity, 0 = even parity
//   STOP_BITS  transmitted stop bits (1 or 2); RX checks the first only
//
// Ports
//   sysclk          system clock
//   sysrstl         asynchronous active-low reset
//   tx_o            serial transmit line, idles high
//   tx_valid_i      transmit word offered
//   tx_data_i       transmit word
//   tx_ready_o      transmitter idle, word can be accepted
//   rx_i            serial receive line (asynchronous to sysclk)
//   rx_data_o       received word
//   rx_valid_o      received word held
//   rx_ready_i      consumer accepts the held word
//   rx_frame_err_o  first stop bit sampled low; qualifies rx_data_o
//   rx_parity_err_o parity mismatch; qualifies rx_data_o
//   rx_overrun_o    one-cycle pulse when an unread word is overwritten
// ---------------------------------------------------------------------------
module uart_core_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sysclk,
  input  logic                 sysrstl,
  output logic                 tx_o,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready_o,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_overrun_o
);

  localparam int CW = $clog2(OVS);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] MID_START = CW'(OVS / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uartState_t;

  // Parity bit that accompanies a data word on the line.
  function automatic logic parityOf(input logic [DATA_BITS-1:0] word);
    return (^word) ^ ODD_SENSE;
  endfunction

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  uartState_t           txState;
  logic [CW-1:0]        txCnt;
  logic [IW-1:0]        txIdx;
  logic                 txStopIdx;
  logic [DATA_BITS-1:0] txShift;
  logic                 txParity;
  logic                 txLine;
  logic                 txReady;

  always_ff @(posedge sysclk or negedge sysrstl) begin
    if (!sysrstl) begin
      txState   <= ST_IDLE;
      txCnt     <= '0;
      txIdx     <= '0;
      txStopIdx <= 1'b0;
      txShift   <= '0;
      txParity  <= 1'b0;
      txLine    <= 1'b1;
      txReady   <= 1'b1;
    end else begin
      case (txState)
        ST_IDLE: begin
          // Start bit is driven from the very next cycle.
          if (tx_valid_i) begin
            txShift  <= tx_data_i;
            txParity <= parityOf(tx_data_i);
            txLine   <= 1'b0;
            txReady  <= 1'b0;
            txCnt    <= '0;
            txState  <= ST_START;
          end
        end
        ST_START: begin
          if (txCnt == BIT_LAST) begin
            txCnt   <= '0;
            txIdx   <= '0;
            txLine  <= txShift[0];
            txShift <= txShift >> 1;
            txState <= ST_DATA;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (txCnt == BIT_LAST) begin
            txCnt <= '0;
            if (txIdx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                txLine  <= txParity;
                txState <= ST_PARITY;
              end else begin
                txLine    <= 1'b1;
                txStopIdx <= 1'b0;
                txState   <= ST_STOP;
              end
            end else begin
              txIdx   <= txIdx + 1'b1;
              txLine  <= txShift[0];
              txShift <= txShift >> 1;
            end
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (txCnt == BIT_LAST) begin
            txCnt     <= '0;
            txLine    <= 1'b1;
            txStopIdx <= 1'b0;
            txState   <= ST_STOP;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (txCnt == BIT_LAST) begin
            txCnt <= '0;
            if (txStopIdx == STOP_LAST) begin
              // Ready rises here, so consecutive words always see one
              // idle-high cycle between the last stop bit and the next start.
              txReady <= 1'b1;
              txState <= ST_IDLE;
            end else begin
              txStopIdx <= 1'b1;
            end
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        default: begin
          txState <= ST_IDLE;
          txLine  <= 1'b1;
          txReady <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o       = txLine;
  assign tx_ready_o = txReady;

  // -------------------------------------------------------------------------
  // Receiver: synchroniser, bit FSM, delivery
  // -------------------------------------------------------------------------
  logic rxMeta;
  logic rxSync;

  always_ff @(posedge sysclk or negedge sysrstl) begin
    if (!sysrstl) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx_i;
      rxSync <= rxMeta;
    end
  end

  uartState_t           rxState;
  logic [CW-1:0]        rxCnt;
  logic [IW-1:0]        rxIdx;
  logic [DATA_BITS-1:0] rxShift;
  logic                 rxAcc;
  logic                 rxParErr;
  logic                 rxDeliver;

  always_ff @(posedge sysclk or negedge sysrstl) begin
    if (!sysrstl) begin
      rxState  <= ST_IDLE;
      rxCnt    <= '0;
      rxIdx    <= '0;
      rxShift  <= '0;
      rxAcc    <= 1'b0;
      rxParErr <= 1'b0;
    end else begin
      case (rxState)
        ST_IDLE: begin
          if (!rxSync) begin
            rxCnt   <= '0;
            rxState <= ST_START;
          end
        end
        ST_START: begin
          // Mid-start check: a line already back high was only a glitch.
          if (rxCnt == MID_START) begin
            rxCnt <= '0;
            if (rxSync) begin
              rxState <= ST_IDLE;
            end else begin
              rxIdx    <= '0;
              rxAcc    <= 1'b0;
              rxParErr <= 1'b0;
              rxState  <= ST_DATA;
            end
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rxCnt == BIT_LAST) begin
            rxCnt   <= '0;
            rxShift <= {rxSync, rxShift[DATA_BITS-1:1]};
            rxAcc   <= rxAcc ^ rxSync;
            if (rxIdx == IDX_LAST) begin
              rxState <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              rxIdx <= rxIdx + 1'b1;
            end
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (rxCnt == BIT_LAST) begin
            rxCnt    <= '0;
            rxParErr <= (rxAcc ^ rxSync) != ODD_SENSE;
            rxState  <= ST_STOP;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (rxCnt == BIT_LAST) begin
            rxCnt   <= '0;
            rxState <= ST_IDLE;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        default: begin
          rxState <= ST_IDLE;
          rxCnt   <= '0;
        end
      endcase
    end
  end

  // The stop-bit sample completes the frame; outputs load on that edge.
  assign rxDeliver = (rxState == ST_STOP) && (rxCnt == BIT_LAST);

  logic [DATA_BITS-1:0] rxData;
  logic                 rxValid;
  logic                 rxFrameErr;
  logic                 rxParityErr;
  logic                 rxOverrun;

  always_ff @(posedge sysclk or negedge sysrstl) begin
    if (!sysrstl) begin
      rxData      <= '0;
      rxValid     <= 1'b0;
      rxFrameErr  <= 1'b0;
      rxParityErr <= 1'b0;
      rxOverrun   <= 1'b0;
    end else begin
      rxOverrun <= 1'b0;
      if (rxDeliver) begin
        // A held word not being taken this cycle is lost.
        rxData      <= rxShift;
        rxFrameErr  <= ~rxSync;
        rxParityErr <= rxParErr;
        rxValid     <= 1'b1;
        rxOverrun   <= rxValid & ~rx_ready_i;
      end else if (rxValid && rx_ready_i) begin
        rxValid     <= 1'b0;
        rxFrameErr  <= 1'b0;
        rxParityErr <= 1'b0;
      end
    end
  end

  assign rx_data_o       = rxData;
  assign rx_valid_o      = rxValid;
  assign rx_frame_err_o  = rxFrameErr;
  assign rx_parity_err_o = rxParityErr;
  assign rx_overrun_o    = rxOverrun;

endmodule

// File: tb/tb_uart_core_param.sv
module tb_uart_core_param;
  localparam int OVS = 16;

  logic sysclk  = 1'b0;
  logic sysrstl = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Default instance: 8N1
  logic       tx0;
  logic       txValid0 = 1'b0;
  logic [7:0] txData0  = 8'h00;
  logic       txReady0;
  logic       loop0    = 1'b0;
  logic       rxDrv0   = 1'b1;
  logic       rx0;
  logic [7:0] rxData0;
  logic       rxValid0;
  logic       rxReady0 = 1'b1;
  logic       fe0, pe0, ov0;
  assign rx0 = loop0 ? tx0 : rxDrv0;

  // Second instance: 7 data bits, even parity, 2 stop bits
  logic       tx1;
  logic       txValid1 = 1'b0;
  logic [6:0] txData1  = 7'h00;
  logic       txReady1;
  logic       rxDrv1   = 1'b1;
  logic [6:0] rxData1;
  logic       rxValid1;
  logic       rxReady1 = 1'b1;
  logic       fe1, pe1, ov1;

  uart_core_param dut0 (
    .sysclk(sysclk), .sysrstl(sysrstl),
    .tx_o(tx0), .tx_valid_i(txValid0), .tx_data_i(txData0), .tx_ready_o(txReady0),
    .rx_i(rx0), .rx_data_o(rxData0), .rx_valid_o(rxValid0), .rx_ready_i(rxReady0),
    .rx_frame_err_o(fe0), .rx_parity_err_o(pe0), .rx_overrun_o(ov0)
  );

  uart_core_param #(.DATA_BITS(7), .OVS(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .sysclk(sysclk), .sysrstl(sysrstl),
    .tx_o(tx1), .tx_valid_i(txValid1), .tx_data_i(txData1), .tx_ready_o(txReady1),
    .rx_i(rxDrv1), .rx_data_o(rxData1), .rx_valid_o(rxValid1), .rx_ready_i(rxReady1),
    .rx_frame_err_o(fe1), .rx_parity_err_o(pe1), .rx_overrun_o(ov1)
  );

  // Results of the most recent waitRx call
  bit         got;
  logic [8:0] rd;
  logic       rfe, rpe;

  task automatic driveSerial(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rxDrv0 = bits[i];
      else            rxDrv1 = bits[i];
      repeat (OVS) @(posedge sysclk);
    end
  endtask

  task automatic waitRx(input int which, input int maxCyc);
    got = 1'b0; rd = '0; rfe = 1'b0; rpe = 1'b0;
    for (int i = 0; i < maxCyc && !got; i++) begin
      @(negedge sysclk);
      if (which == 0 && rxValid0) begin
        got = 1'b1; rd = {1'b0, rxData0}; rfe = fe0; rpe = pe0;
      end else if (which == 1 && rxValid1) begin
        got = 1'b1; rd = {2'b00, rxData1}; rfe = fe1; rpe = pe1;
      end
    end
  endtask

  task automatic test_reset();
    sysrstl = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++;
    if ({tx0, txReady0, rxValid0, fe0, pe0, ov0} !== 6'b110000) begin
      errors++; $display("FAIL reset_ctl0: got %b expected 110000", {tx0, txReady0, rxValid0, fe0, pe0, ov0});
    end
    checks++;
    if (rxData0 !== 8'h00) begin
      errors++; $display("FAIL reset_data0: got %h expected 00", rxData0);
    end
    checks++;
    if ({tx1, txReady1, rxValid1, fe1, pe1, ov1} !== 6'b110000) begin
      errors++; $display("FAIL reset_ctl1: got %b expected 110000", {tx1, txReady1, rxValid1, fe1, pe1, ov1});
    end
    sysrstl = 1'b1;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic test_tx_a5();
    logic [9:0] exp;
    int bad;
    int readyHigh;
    exp = {1'b1, 8'hA5, 1'b0};
    readyHigh = 0;
    @(negedge sysclk);
    checks++;
    if (txReady0 !== 1'b1) begin
      errors++; $display("FAIL a5_ready_before: got %b expected 1", txReady0);
    end
    txData0 = 8'hA5; txValid0 = 1'b1;
    @(posedge sysclk); #1;
    txValid0 = 1'b0; txData0 = 8'h00;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < OVS; c++) begin
        @(negedge sysclk);
        if (tx0 !== exp[b]) bad++;
        if (txReady0 !== 1'b0) readyHigh++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL a5_bit%0d: %0d wrong cycles, expected level %b for 16 cycles", b, bad, exp[b]);
      end
    end
    checks++;
    if (readyHigh != 0) begin
      errors++; $display("FAIL a5_ready_low: ready high in %0d of 160 cycles, expected 0", readyHigh);
    end
    @(negedge sysclk);
    checks++;
    if ({txReady0, tx0} !== 2'b11) begin
      errors++; $display("FAIL a5_ready_after: got %b expected 11", {txReady0, tx0});
    end
  endtask

  task automatic test_tx_parity();
    logic [6:0]  words [2] = '{7'h55, 7'h54};
    logic        pars  [2] = '{1'b0, 1'b1};
    logic [10:0] exp;
    int bad;
    int readyHigh;
    for (int w = 0; w < 2; w++) begin
      exp = {2'b11, pars[w], words[w], 1'b0};
      readyHigh = 0;
      @(negedge sysclk);
      txData1 = words[w]; txValid1 = 1'b1;
      @(posedge sysclk); #1;
      txValid1 = 1'b0;
      for (int b = 0; b < 11; b++) begin
        bad = 0;
        for (int c = 0; c < OVS; c++) begin
          @(negedge sysclk);
          if (tx1 !== exp[b]) bad++;
          if (txReady1 !== 1'b0) readyHigh++;
        end
        checks++;
        if (bad != 0) begin
          errors++; $display("FAIL par_tx_w%0d_bit%0d: %0d wrong cycles, expected level %b", w, b, bad, exp[b]);
        end
      end
      checks++;
      if (readyHigh != 0) begin
        errors++; $display("FAIL par_tx_ready_low_w%0d: high in %0d of 176 cycles, expected 0", w, readyHigh);
      end
      @(negedge sysclk);
      checks++;
      if (txReady1 !== 1'b1) begin
        errors++; $display("FAIL par_tx_ready_after_w%0d: got %b expected 1", w, txReady1);
      end
    end
  endtask

  task automatic test_loopback();
    int acc1, acc2;
    bit ok2;
    logic [8:0] d1, d2;
    logic [1:0] e1, e2;
    bit g1, g2;
    acc1 = 0; acc2 = 0; ok2 = 1'b0;
    loop0 = 1'b1; rxReady0 = 1'b1;
    repeat (4) @(negedge sysclk);
    fork
      begin
        @(negedge sysclk);
        txData0 = 8'h3C; txValid0 = 1'b1;
        acc1 = cyc;
        @(posedge sysclk); #1;
        txData0 = 8'hC3;
        for (int i = 0; i < 300 && !ok2; i++) begin
          @(negedge sysclk);
          if (txReady0) begin ok2 = 1'b1; acc2 = cyc; end
        end
        @(posedge sysclk); #1;
        txValid0 = 1'b0;
      end
      begin
        waitRx(0, 400); g1 = got; d1 = rd; e1 = {rfe, rpe};
        waitRx(0, 400); g2 = got; d2 = rd; e2 = {rfe, rpe};
      end
    join
    checks++;
    if (!ok2 || (acc2 - acc1) != 161) begin
      errors++; $display("FAIL b2b_gap: accept spacing %0d (seen %0d), expected 161", acc2 - acc1, ok2);
    end
    checks++;
    if (!g1 || d1 !== 9'h03C || e1 !== 2'b00) begin
      errors++; $display("FAIL loop_word1: got valid=%0d data=%h err=%b expected 1/03c/00", g1, d1, e1);
    end
    checks++;
    if (!g2 || d2 !== 9'h0C3 || e2 !== 2'b00) begin
      errors++; $display("FAIL loop_word2: got valid=%0d data=%h err=%b expected 1/0c3/00", g2, d2, e2);
    end
    checks++;
    if (ov0 !== 1'b0) begin
      errors++; $display("FAIL loop_overrun: got %b expected 0", ov0);
    end
    repeat (200) @(negedge sysclk);
    loop0 = 1'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic test_parity_rx();
    logic pbits [2] = '{1'b1, 1'b0};
    logic pexp  [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      fork
        driveSerial(1, {6'b0, 1'b1, pbits[k], 7'h55, 1'b0}, 10);
        waitRx(1, 250);
      join
      checks++;
      if (!got || rd !== 9'h055 || rpe !== pexp[k] || rfe !== 1'b0) begin
        errors++; $display("FAIL parity_rx_%0d: got valid=%0d data=%h pe=%b fe=%b expected 1/055/%b/0",
                           k, got, rd, rpe, rfe, pexp[k]);
      end
      repeat (20) @(negedge sysclk);
    end
    checks++;
    if (ov1 !== 1'b0) begin
      errors++; $display("FAIL parity_rx_overrun: got %b expected 0", ov1);
    end
  endtask

  task automatic test_frame_err();
    int seen;
    rxReady0 = 1'b1;
    fork
      driveSerial(0, {6'b0, 1'b0, 8'h81, 1'b0}, 10);
      waitRx(0, 250);
    join
    checks++;
    if (!got || rd !== 9'h081 || rfe !== 1'b1 || rpe !== 1'b0) begin
      errors++; $display("FAIL frame_err: got valid=%0d data=%h fe=%b pe=%b expected 1/081/1/0", got, rd, rfe, rpe);
    end
    @(negedge sysclk);
    checks++;
    if ({rxValid0, fe0} !== 2'b00) begin
      errors++; $display("FAIL accept_clear: got valid/fe=%b expected 00", {rxValid0, fe0});
    end
    // Line still low: a break frame follows with data 0.
    waitRx(0, 250);
    rxDrv0 = 1'b1;
    checks++;
    if (!got || rd !== 9'h000 || rfe !== 1'b1) begin
      errors++; $display("FAIL break_frame: got valid=%0d data=%h fe=%b expected 1/000/1", got, rd, rfe);
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (rxValid0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL break_release: valid seen %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_glitch();
    int seen;
    @(posedge sysclk); #1;
    rxDrv0 = 1'b0;
    repeat (5) @(posedge sysclk);
    #1 rxDrv0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sysclk);
      if (rxValid0 || fe0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL glitch_reject: valid/fe seen %0d cycles, expected 0", seen);
    end
    fork
      driveSerial(0, {6'b0, 1'b1, 8'h12, 1'b0}, 10);
      waitRx(0, 250);
    join
    checks++;
    if (!got || rd !== 9'h012 || rfe !== 1'b0 || rpe !== 1'b0) begin
      errors++; $display("FAIL after_glitch: got valid=%0d data=%h fe=%b pe=%b expected 1/012/0/0", got, rd, rfe, rpe);
    end
    repeat (10) @(negedge sysclk);
  endtask

  task automatic test_overrun();
    int ovCount;
    ovCount = 0;
    rxReady0 = 1'b0;
    fork
      begin
        driveSerial(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        repeat (4) @(posedge sysclk);
        driveSerial(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
      end
      for (int i = 0; i < 400; i++) begin
        @(negedge sysclk);
        if (ov0) ovCount++;
      end
    join
    checks++;
    if (ovCount != 1) begin
      errors++; $display("FAIL overrun_pulses: got %0d expected 1", ovCount);
    end
    checks++;
    if (rxValid0 !== 1'b1 || rxData0 !== 8'h22 || fe0 !== 1'b0) begin
      errors++; $display("FAIL overrun_data: got valid=%b data=%h fe=%b expected 1/22/0", rxValid0, rxData0, fe0);
    end
  endtask

  task automatic test_reset_mid_tx();
    @(negedge sysclk);
    txData0 = 8'h00; txValid0 = 1'b1;
    @(posedge sysclk); #1;
    txValid0 = 1'b0;
    repeat (30) @(posedge sysclk);
    #2;
    checks++;
    if ({tx0, txReady0} !== 2'b00) begin
      errors++; $display("FAIL pre_reset_tx: got tx/ready=%b expected 00", {tx0, txReady0});
    end
    sysrstl = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1) begin
      errors++; $display("FAIL reset_tx_immediate: got %b expected 1", tx0);
    end
    checks++;
    if (rxValid0 !== 1'b0 || rxData0 !== 8'h00) begin
      errors++; $display("FAIL reset_rx_clear: got valid=%b data=%h expected 0/00", rxValid0, rxData0);
    end
    repeat (2) @(negedge sysclk);
    sysrstl = 1'b1;
    rxReady0 = 1'b1;
    @(negedge sysclk);
    checks++;
    if ({txReady0, tx0, rxValid0} !== 3'b110) begin
      errors++; $display("FAIL after_reset_release: got ready/tx/valid=%b expected 110", {txReady0, tx0, rxValid0});
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_a5();
    test_tx_parity();
    test_loopback();
    test_parity_rx();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
